// File: rtl/alu_instr_sequencer_pkg.sv
// Shared types and constants for the register-register ALU instruction sequencer.
// Holds the state encoding, opcode/ALUop maps, IR field positions and the control word.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        CLS_BINARY, CLS_UNARY, CLS_MULDIV, CLS_OTHER
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_NEG  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_NEG  = 4'd9;
    localparam logic [3:0] ALU_NOT  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;

    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    typedef struct packed {
        logic       pc_in;
        logic       pc_out;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       zlow_in;
        logic       zhigh_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       hi_in;
        logic       lo_in;
        logic       read;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       halted;
        logic       fault;
    } ctrl_t;

    function automatic op_class_e op_class(input logic [4:0] opc);
        if (opc <= OP_ROL)
            return CLS_BINARY;
        else if (opc == OP_NEG || opc == OP_NOT)
            return CLS_UNARY;
        else if (opc == OP_MUL || opc == OP_DIV)
            return CLS_MULDIV;
        else
            return CLS_OTHER;
    endfunction

    function automatic logic [3:0] alu_sel(input logic [4:0] opc);
        logic [3:0] sel;
        case (opc)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_SHR:  sel = ALU_SHR;
            OP_SHRA: sel = ALU_SHRA;
            OP_SHL:  sel = ALU_SHL;
            OP_ROR:  sel = ALU_ROR;
            OP_ROL:  sel = ALU_ROL;
            OP_NEG:  sel = ALU_NEG;
            OP_NOT:  sel = ALU_NOT;
            OP_MUL:  sel = ALU_MUL;
            OP_DIV:  sel = ALU_DIV;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bus between the instruction sequencer (master) and the datapath (slave).
interface alu_instr_sequencer_if;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic        Read;
    logic [3:0]  ALUop;
    logic        instr_done;
    logic        halted;
    logic        fault;

    modport master (
        input  run, mem_ready, IR,
        output Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
               Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read, ALUop,
               instr_done, halted, fault
    );

    modport slave (
        output run, mem_ready, IR,
        input  Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
               Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read, ALUop,
               instr_done, halted, fault
    );
endinterface

// File: rtl/alu_instr_sequencer_reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; all-zero when disabled.
module reg_select_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);
    assign onehot = en ? (16'h0001 << idx) : 16'h0000;
endmodule

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle fetch/execute control unit for register-register ALU instructions.
// All outputs are registered and decoded from the next state, so they track the state register.
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 clock,
    input  logic                 clear,
    alu_instr_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [4:0]        opc_q, opc_d;
    logic [3:0]        ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    op_class_e         cls_q, cls_d;
    logic              last_step;

    ctrl_t             ctrl_q, ctrl_d;
    logic [15:0]       rin_q, rin_d, rout_q, rout_d;
    logic [3:0]        rin_idx_d, rout_idx_d;
    logic              rin_en_d, rout_en_d;

    // The low IR bits hold immediates this unit never looks at.
    logic              unused_ir;
    assign unused_ir = ^bus.IR[RC_LSB-1:0];

    assign cls_q = op_class(opc_q);
    assign cls_d = op_class(opc_d);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        opc_d     = opc_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rc_d      = rc_q;
        last_step = ((state_q == S_T4) && (cls_q == CLS_UNARY)) ||
                    ((state_q == S_T5) && (cls_q == CLS_BINARY)) ||
                    (state_q == S_T6);
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                wait_d  = '0;
            end
            S_T1: begin
                if (bus.mem_ready)
                    state_d = S_T2;
                else if (wait_q == WAIT_LAST)
                    state_d = S_FAULT;
                else
                    wait_d = wait_q + 1'b1;
            end
            S_T2: begin
                state_d = S_T3;
                opc_d   = bus.IR[OPC_LSB +: 5];
                ra_d    = bus.IR[RA_LSB +: 4];
                rb_d    = bus.IR[RB_LSB +: 4];
                rc_d    = bus.IR[RC_LSB +: 4];
            end
            S_T3: begin
                if (cls_q == CLS_OTHER)
                    state_d = (opc_q == OP_HALT) ? S_HALT : S_FAULT;
                else
                    state_d = S_T4;
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_IDLE;
            default: state_d = state_q;
        endcase
        // Back-to-back instructions skip IDLE when run is still high at the final step.
        if (last_step)
            state_d = bus.run ? S_T0 : S_IDLE;
    end

    always_comb begin
        ctrl_d     = '0;
        rin_en_d   = 1'b0;
        rout_en_d  = 1'b0;
        rin_idx_d  = ra_d;
        rout_idx_d = rb_d;
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out  = 1'b1;
                ctrl_d.mar_in  = 1'b1;
                ctrl_d.inc_pc  = 1'b1;
                ctrl_d.zlow_in = 1'b1;
            end
            S_T1: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls_d)
                    CLS_BINARY: begin
                        rout_en_d   = 1'b1;
                        ctrl_d.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en_d      = 1'b1;
                        ctrl_d.alu_op  = alu_sel(opc_d);
                        ctrl_d.zlow_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en_d   = 1'b1;
                        rout_idx_d  = ra_d;
                        ctrl_d.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_d)
                    CLS_BINARY: begin
                        rout_en_d      = 1'b1;
                        rout_idx_d     = rc_d;
                        ctrl_d.alu_op  = alu_sel(opc_d);
                        ctrl_d.zlow_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl_d.zlow_out   = 1'b1;
                        rin_en_d          = 1'b1;
                        ctrl_d.instr_done = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en_d       = 1'b1;
                        ctrl_d.alu_op   = alu_sel(opc_d);
                        ctrl_d.zlow_in  = 1'b1;
                        ctrl_d.zhigh_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                ctrl_d.zlow_out = 1'b1;
                if (cls_d == CLS_BINARY) begin
                    rin_en_d          = 1'b1;
                    ctrl_d.instr_done = 1'b1;
                end else begin
                    ctrl_d.lo_in = 1'b1;
                end
            end
            S_T6: begin
                ctrl_d.zhigh_out  = 1'b1;
                ctrl_d.hi_in      = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            S_FAULT: ctrl_d.fault  = 1'b1;
            default: ;
        endcase
    end

    reg_select_decoder u_rin_dec  (.idx(rin_idx_d),  .en(rin_en_d),  .onehot(rin_d));
    reg_select_decoder u_rout_dec (.idx(rout_idx_d), .en(rout_en_d), .onehot(rout_d));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            ctrl_q  <= '0;
            rin_q   <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            opc_q   <= opc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            ctrl_q  <= ctrl_d;
            rin_q   <= rin_d;
            rout_q  <= rout_d;
        end
    end

    assign bus.Rin        = rin_q;
    assign bus.Rout       = rout_q;
    assign bus.PCin       = ctrl_q.pc_in;
    assign bus.PCout      = ctrl_q.pc_out;
    assign bus.IncPC      = ctrl_q.inc_pc;
    assign bus.MARin      = ctrl_q.mar_in;
    assign bus.MDRin      = ctrl_q.mdr_in;
    assign bus.MDRout     = ctrl_q.mdr_out;
    assign bus.IRin       = ctrl_q.ir_in;
    assign bus.Yin        = ctrl_q.y_in;
    assign bus.Zlowin     = ctrl_q.zlow_in;
    assign bus.Zhighin    = ctrl_q.zhigh_in;
    assign bus.Zlowout    = ctrl_q.zlow_out;
    assign bus.Zhighout   = ctrl_q.zhigh_out;
    assign bus.HIin       = ctrl_q.hi_in;
    assign bus.LOin       = ctrl_q.lo_in;
    assign bus.Read       = ctrl_q.read;
    assign bus.ALUop      = ctrl_q.alu_op;
    assign bus.instr_done = ctrl_q.instr_done;
    assign bus.halted     = ctrl_q.halted;
    assign bus.fault      = ctrl_q.fault;

endmodule
